// File: rtl/absorb_stream_unit_if.sv
// Message beat stream into the absorber: byte-keyed data with keep mask and last flag.
// A beat transfers on a rising clk edge where msg_valid and msg_ready are both high; the
// master holds msg/keep/last stable while msg_valid is high and msg_ready is low.
interface absorb_stream_unit_if #(
    parameter int DWIDTH     = 256,
    parameter int KEEP_WIDTH = DWIDTH / 8
);
    logic                  msg_valid;
    logic                  msg_ready;
    logic [DWIDTH-1:0]     msg;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;

    modport master (output msg_valid, msg, keep, last, input msg_ready);
    modport slave  (input msg_valid, msg, keep, last, output msg_ready);
endinterface

// File: rtl/absorb_stream_unit.sv
// Sequential Keccak absorber: XORs byte-keyed beats into the state at any byte offset,
// carries overflow bytes across permutations and applies multi-rate padding.
module absorb_stream_unit #(
    parameter int DWIDTH     = 256,
    parameter int KEEP_WIDTH = DWIDTH / 8,
    parameter int RATE_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic [7:0]            suffix_i,
    absorb_stream_unit_if.slave   msg_if,
    input  logic [4:0][4:0][63:0] state_array_i,
    output logic [4:0][4:0][63:0] state_array_o,
    output logic                  state_we_o,
    output logic                  perm_req_o,
    input  logic                  perm_done_i,
    output logic                  absorb_done_o,
    output logic [2:0]            fsm_state_o
);
    localparam int SW  = 1600;
    localparam int RBW = RATE_WIDTH - 3;
    localparam int NW  = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ABSORB    = 3'd1,
        S_PAD       = 3'd2,
        S_PERM_WAIT = 3'd3,
        S_DONE      = 3'd4
    } fsm_t;

    fsm_t                  state, state_n;
    logic [RBW-1:0]        byte_cnt, byte_cnt_n;
    logic [RBW-1:0]        rate_bytes, rate_bytes_n;
    logic [7:0]            suffix, suffix_n;
    logic [DWIDTH-1:0]     carry_data, carry_data_n;
    logic [KEEP_WIDTH-1:0] carry_keep, carry_keep_n;
    logic                  carry_valid, carry_valid_n;
    logic                  carry_last, carry_last_n;
    logic                  pad_pending, pad_pending_n;
    logic                  final_flag, final_flag_n;

    logic [DWIDTH-1:0]     msg_masked, src_data;
    logic [KEEP_WIDTH-1:0] src_keep;
    logic [NW-1:0]         src_cnt;
    logic [RBW-1:0]        space, rate_last;
    logic [SW-1:0]         rate_mask, place_vec, pad_vec, xor_lin;
    logic                  ready_c, we_c;

    // The three low rate bits are always zero for legal rates.
    logic unused_rate_bits;
    assign unused_rate_bits = ^rate_i[2:0];

    assign space     = rate_bytes - byte_cnt;
    assign rate_last = rate_bytes - RBW'(1);

    always_comb begin
        msg_masked = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (msg_if.keep[i]) msg_masked[8*i +: 8] = msg_if.msg[8*i +: 8];
        end
        src_data = carry_valid ? carry_data : msg_masked;
        src_keep = carry_valid ? carry_keep : msg_if.keep;
        src_cnt  = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            src_cnt = src_cnt + NW'(src_keep[i]);
        end
        for (int b = 0; b < SW / 8; b++) begin
            rate_mask[8*b +: 8] = (b < int'(rate_bytes)) ? 8'hFF : 8'h00;
        end
        // Bytes pushed past the rate boundary are clipped here; they return later as the carry.
        place_vec = (SW'(src_data) << {byte_cnt, 3'b000}) & rate_mask;
        pad_vec   = (SW'(suffix) << {byte_cnt, 3'b000}) ^ (SW'(8'h80) << {rate_last, 3'b000});
    end

    always_comb begin
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        rate_bytes_n  = rate_bytes;
        suffix_n      = suffix;
        carry_data_n  = carry_data;
        carry_keep_n  = carry_keep;
        carry_valid_n = carry_valid;
        carry_last_n  = carry_last;
        pad_pending_n = pad_pending;
        final_flag_n  = final_flag;
        ready_c       = 1'b0;
        we_c          = 1'b0;
        xor_lin       = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    rate_bytes_n  = rate_i[RATE_WIDTH-1:3];
                    suffix_n      = suffix_i;
                    byte_cnt_n    = '0;
                    carry_data_n  = '0;
                    carry_keep_n  = '0;
                    carry_valid_n = 1'b0;
                    carry_last_n  = 1'b0;
                    pad_pending_n = 1'b0;
                    final_flag_n  = 1'b0;
                    state_n       = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (carry_valid) begin
                    we_c          = 1'b1;
                    xor_lin       = place_vec;
                    carry_valid_n = 1'b0;
                    byte_cnt_n    = RBW'(src_cnt);
                    if (carry_last) state_n = S_PAD;
                end else begin
                    ready_c = 1'b1;
                    if (msg_if.msg_valid) begin
                        we_c    = 1'b1;
                        xor_lin = place_vec;
                        if (int'(src_cnt) < int'(space)) begin
                            byte_cnt_n = byte_cnt + RBW'(src_cnt);
                            if (msg_if.last) state_n = S_PAD;
                        end else begin
                            byte_cnt_n = '0;
                            state_n    = S_PERM_WAIT;
                            if (int'(src_cnt) > int'(space)) begin
                                carry_data_n  = src_data >> {space, 3'b000};
                                carry_keep_n  = src_keep >> space;
                                carry_valid_n = 1'b1;
                                carry_last_n  = msg_if.last;
                            end else if (msg_if.last) begin
                                // Padding needs a fresh block after this permutation.
                                pad_pending_n = 1'b1;
                            end
                        end
                    end
                end
            end
            S_PAD: begin
                we_c         = 1'b1;
                xor_lin      = pad_vec;
                final_flag_n = 1'b1;
                state_n      = S_PERM_WAIT;
            end
            S_PERM_WAIT: begin
                if (perm_done_i) begin
                    if (final_flag) begin
                        state_n = S_DONE;
                    end else if (pad_pending) begin
                        byte_cnt_n    = '0;
                        pad_pending_n = 1'b0;
                        state_n       = S_PAD;
                    end else begin
                        state_n = S_ABSORB;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            rate_bytes  <= '0;
            suffix      <= '0;
            carry_data  <= '0;
            carry_keep  <= '0;
            carry_valid <= 1'b0;
            carry_last  <= 1'b0;
            pad_pending <= 1'b0;
            final_flag  <= 1'b0;
        end else begin
            state       <= state_n;
            byte_cnt    <= byte_cnt_n;
            rate_bytes  <= rate_bytes_n;
            suffix      <= suffix_n;
            carry_data  <= carry_data_n;
            carry_keep  <= carry_keep_n;
            carry_valid <= carry_valid_n;
            carry_last  <= carry_last_n;
            pad_pending <= pad_pending_n;
            final_flag  <= final_flag_n;
        end
    end

    // Linear lane L = 5*y + x holds state bytes 8L..8L+7.
    always_comb begin
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                state_array_o[x][y] = state_array_i[x][y] ^ xor_lin[64*(5*y + x) +: 64];
            end
        end
    end

    assign msg_if.msg_ready = ready_c;
    assign state_we_o       = we_c;
    assign perm_req_o       = (state == S_PERM_WAIT);
    assign absorb_done_o    = (state == S_DONE);
    assign fsm_state_o      = state;
endmodule

// File: tb/tb_absorb_stream_unit.sv
// Bench for absorb_stream_unit: a byte-level absorb model pushes expected state deltas,
// a negedge monitor pops them on every state_we_o; the bench owns the state register.
module tb_absorb_stream_unit;
    localparam int DWIDTH = 256;
    localparam int KW     = DWIDTH / 8;
    localparam int RW     = 11;
    localparam int SW     = 1600;

    typedef logic [4:0][4:0][63:0] st_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [RW-1:0] rate;
    logic [7:0]    suffix;
    st_t           state_in, state_out;
    logic          state_we, perm_req, perm_done, absorb_done;
    logic [2:0]    fsm_state;

    absorb_stream_unit_if #(.DWIDTH(DWIDTH), .KEEP_WIDTH(KW)) msg_if ();

    absorb_stream_unit #(.DWIDTH(DWIDTH), .KEEP_WIDTH(KW), .RATE_WIDTH(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .rate_i       (rate),
        .suffix_i     (suffix),
        .msg_if       (msg_if),
        .state_array_i(state_in),
        .state_array_o(state_out),
        .state_we_o   (state_we),
        .perm_req_o   (perm_req),
        .perm_done_i  (perm_done),
        .absorb_done_o(absorb_done),
        .fsm_state_o  (fsm_state)
    );

    always #5 clk = ~clk;

    st_t           seed_state, state_reg;
    logic [SW-1:0] seed_lin, m_state;
    logic [SW-1:0] exp_q[$];
    int            n_cmp, n_fail;
    int            perm_count, perm_base, perm_delay;
    int            m_pos, m_rate, m_blocks;
    logic [7:0]    m_sfx;

    always @(posedge clk) begin
        if (!rst) state_reg <= seed_state;
        else if (state_we) state_reg <= state_out;
    end
    assign state_in = state_reg;

    function automatic st_t to_arr(input logic [SW-1:0] lin);
        st_t a;
        for (int l = 0; l < 25; l++) a[l % 5][l / 5] = lin[64*l +: 64];
        return a;
    endfunction

    task automatic scoreboard_monitor();
        logic [SW-1:0] e;
        st_t d, ex;
        int fx, fy;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && state_we === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_write t=%0t state_we_o got 1 required 0", $time);
                end else begin
                    e  = exp_q.pop_front();
                    ex = to_arr(e);
                    d  = state_out ^ state_in;
                    if (d !== ex) begin
                        n_fail++;
                        fx = 0; fy = 0;
                        for (int x = 4; x >= 0; x--)
                            for (int y = 4; y >= 0; y--)
                                if (d[x][y] !== ex[x][y]) begin fx = x; fy = y; end
                        $display("FAIL sb_delta t=%0t lane x=%0d y=%0d got %h required %h",
                                 $time, fx, fy, d[fx][fy], ex[fx][fy]);
                    end
                end
            end
        end
    endtask

    task automatic perm_responder();
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && perm_req === 1'b1) begin
                repeat (perm_delay) @(negedge clk);
                perm_done = 1'b1;
                perm_count++;
                @(negedge clk);
                perm_done = 1'b0;
            end
        end
    endtask

    task automatic start_msg(input int rate_bits, input logic [7:0] sfx);
        @(posedge clk); #1;
        start  = 1'b1;
        rate   = RW'(rate_bits);
        suffix = sfx;
        @(posedge clk); #1;
        start     = 1'b0;
        m_pos     = 0;
        m_rate    = rate_bits / 8;
        m_sfx     = sfx;
        m_blocks  = 0;
        perm_base = perm_count;
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase after the handshake.
    task automatic send_beat(input int n, input bit last, input int gap);
        logic [DWIDTH-1:0] data;
        logic [KW-1:0]     keep;
        logic [SW-1:0]     ev;
        int                cyc;
        for (int i = 0; i < DWIDTH / 32; i++) data[32*i +: 32] = $urandom;
        for (int i = 0; i < KW; i++) keep[i] = (i < n);
        ev = '0;
        for (int k = 0; k < n; k++) begin
            ev[m_pos*8 +: 8] ^= data[8*k +: 8];
            m_pos++;
            if (m_pos == m_rate) begin
                m_pos = 0;
                m_blocks++;
                if (k < n - 1) begin
                    exp_q.push_back(ev);
                    m_state ^= ev;
                    ev = '0;
                end
            end
        end
        exp_q.push_back(ev);
        m_state ^= ev;
        if (last) begin
            ev = '0;
            ev[m_pos*8 +: 8]      ^= m_sfx;
            ev[(m_rate-1)*8 +: 8] ^= 8'h80;
            exp_q.push_back(ev);
            m_state ^= ev;
            m_blocks++;
        end
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        msg_if.msg       = data;
        msg_if.keep      = keep;
        msg_if.last      = last;
        msg_if.msg_valid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (msg_if.msg_ready !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (msg_if.msg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL beat_accept_timeout msg_ready_o got %b required 1", msg_if.msg_ready);
        end
        @(posedge clk); #1;
        msg_if.msg_valid = 1'b0;
    endtask

    task automatic finish_msg(input string name);
        st_t exp_st;
        int  cyc, fx, fy;
        cyc = 0;
        @(negedge clk);
        while (absorb_done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (absorb_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done absorb_done_o got %b required 1", name, absorb_done);
        end
        n_cmp++;
        if (perm_count - perm_base !== m_blocks) begin
            n_fail++;
            $display("FAIL %s_perms permutations got %0d required %0d", name, perm_count - perm_base, m_blocks);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes pending writes got %0d required 0", name, exp_q.size());
            exp_q.delete();
        end
        exp_st = to_arr(m_state);
        n_cmp++;
        if (state_reg !== exp_st) begin
            n_fail++;
            fx = 0; fy = 0;
            for (int x = 4; x >= 0; x--)
                for (int y = 4; y >= 0; y--)
                    if (state_reg[x][y] !== exp_st[x][y]) begin fx = x; fy = y; end
            $display("FAIL %s_state lane x=%0d y=%0d got %h required %h",
                     name, fx, fy, state_reg[fx][fy], exp_st[fx][fy]);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (absorb_done !== 1'b1 || msg_if.msg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_hold done/ready got %b%b required 10", name, absorb_done, msg_if.msg_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; rate = '0; suffix = '0; perm_done = 1'b0;
        msg_if.msg_valid = 1'b0; msg_if.msg = '0; msg_if.keep = '0; msg_if.last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL reset_fsm got %0d required 0", fsm_state); end
        n_cmp++; if (msg_if.msg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b required 0", msg_if.msg_ready); end
        n_cmp++; if (state_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b required 0", state_we); end
        n_cmp++; if (perm_req !== 1'b0) begin n_fail++; $display("FAIL reset_perm_req got %b required 0", perm_req); end
        n_cmp++; if (absorb_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b required 0", absorb_done); end
        @(posedge clk); #1;
        rst = 1'b1;
        m_state = seed_lin;
    endtask

    task automatic test_empty();
        start_msg(1088, 8'h06);
        send_beat(0, 1'b1, 0);
        finish_msg("empty");
    endtask

    task automatic test_unaligned();
        start_msg(1088, 8'h06);
        for (int i = 0; i < 3; i++) send_beat(5, i == 2, 0);
        finish_msg("unaligned");
    endtask

    task automatic test_carry();
        int cyc;
        start_msg(1088, 8'h06);
        for (int i = 0; i < 5; i++) send_beat(32, i == 4, 0);
        n_cmp++;
        if (perm_req !== 1'b1) begin n_fail++; $display("FAIL carry_perm_req got %b required 1", perm_req); end
        cyc = 0;
        @(posedge clk);
        while (perm_done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        n_cmp++;
        if (perm_done !== 1'b1) begin n_fail++; $display("FAIL carry_perm_timeout perm_done got %b required 1", perm_done); end
        @(negedge clk);
        n_cmp++;
        if (msg_if.msg_ready !== 1'b0 || state_we !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_cycle ready/we got %b%b required 01", msg_if.msg_ready, state_we);
        end
        finish_msg("carry");
    endtask

    task automatic test_exact_fill();
        start_msg(1088, 8'h06);
        for (int i = 0; i < 4; i++) send_beat(32, 1'b0, 0);
        send_beat(8, 1'b1, 0);
        finish_msg("exact_fill");
    endtask

    task automatic test_same_byte_pad();
        start_msg(1344, 8'h1F);
        for (int i = 0; i < 5; i++) send_beat(32, 1'b0, 1);
        send_beat(7, 1'b1, 0);
        finish_msg("same_byte");
    endtask

    task automatic test_stall();
        perm_delay = 30;
        start_msg(1088, 8'h06);
        for (int i = 0; i < 5; i++) send_beat(32, 1'b0, 0);
        start = 1'b1;
        rate  = RW'(576);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            n_cmp++;
            if (perm_req !== 1'b1 || msg_if.msg_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d req/ready got %b%b required 10", i, perm_req, msg_if.msg_ready);
            end
        end
        @(posedge clk); #1;
        send_beat(4, 1'b1, 0);
        finish_msg("stall");
        perm_delay = 2;
    endtask

    task automatic test_mid_reset();
        start_msg(832, 8'h1F);
        send_beat(10, 1'b0, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL midrst_fsm got %0d required 0", fsm_state); end
        n_cmp++; if (msg_if.msg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b required 0", msg_if.msg_ready); end
        n_cmp++; if (state_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b required 0", state_we); end
        n_cmp++; if (perm_req !== 1'b0) begin n_fail++; $display("FAIL midrst_perm_req got %b required 0", perm_req); end
        n_cmp++; if (absorb_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b required 0", absorb_done); end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        m_state = seed_lin;
    endtask

    task automatic test_back_to_back();
        int         rates[5];
        int         len, rem, n;
        logic [7:0] sfx;
        rates = '{1152, 1088, 832, 576, 1344};
        for (int m = 0; m < 6; m++) begin
            perm_delay = $urandom_range(0, 3);
            sfx = ($urandom_range(0, 1) == 1) ? 8'h06 : 8'h1F;
            len = $urandom_range(0, 400);
            start_msg(rates[$urandom_range(0, 4)], sfx);
            rem = len;
            do begin
                n = $urandom_range(1, 32);
                if (n > rem) n = rem;
                rem -= n;
                send_beat(n, rem == 0, $urandom_range(0, 2));
            end while (rem > 0);
            finish_msg("b2b");
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        perm_count = 0;
        perm_base  = 0;
        perm_delay = 2;
        perm_done  = 1'b0;
        rst        = 1'b0;
        for (int l = 0; l < SW / 32; l++) seed_lin[32*l +: 32] = $urandom;
        seed_state = to_arr(seed_lin);
        m_state    = seed_lin;
        fork
            scoreboard_monitor();
            perm_responder();
        join_none
        test_reset();
        test_empty();
        test_unaligned();
        test_carry();
        test_exact_fill();
        test_same_byte_pad();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/absorb_stream_unit.md
# absorb_stream_unit

Sequential, parametrised successor to the combinational lane absorber. It accepts a byte-keyed message stream of configurable width and XORs it into the Keccak state at arbitrary byte offsets, with no 64-bit alignment requirement. It buffers overflow bytes internally, requests a permutation whenever a rate block fills, and applies SHA3/SHAKE multi-rate padding on the last beat. It sits between the message input stream and the state register / permutation core.

## Interface
- DWIDTH, 256: message beat width in bits; multiple of 64, range 64..512, so a carry always fits in one fresh block.
- KEEP_WIDTH, DWIDTH/8: one keep bit per byte.
- RATE_WIDTH, 11: width of rate_i in bits.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-low.
- start_i  in  1  starts a new absorb; sampled in IDLE or DONE only.
- rate_i  in  RATE_WIDTH  rate in bits (1152/1088/832/576/1344); latched on start_i.
- suffix_i  in  8  domain-separation byte (0x06 SHA3, 0x1F SHAKE); latched on start_i.
- msg_valid_i  in  1  beat valid.
- msg_ready_o  out  1  beat accepted when high together with msg_valid_i.
- msg_i  in  DWIDTH  message bytes, byte 0 in bits [7:0].
- keep_i  in  KEEP_WIDTH  contiguous from bit 0; all-zero is legal only with last_i.
- last_i  in  1  final beat of the message.
- state_array_i  in  5x5x64  current state.
- state_array_o  out  5x5x64  state_array_i XOR placed bytes; combinational.
- state_we_o  out  1  owner loads state_array_o this cycle.
- perm_req_o  out  1  permutation request; level signal.
- perm_done_i  in  1  one-cycle pulse when the permutation completes.
- absorb_done_o  out  1  final padded block permuted; held until next start_i.

## Operation
- Registers: FSM state, byte_cnt (0..rate_bytes-1), rate_bytes = rate_i>>3, suffix, carry_data/carry_keep/carry_valid/carry_last, pad_pending, final_flag.
- Placement: byte k of the source (k < n = popcount(keep)) XORs into linear state byte byte_cnt+k. Linear byte b maps to lane L=b>>3, x=L%5, y=L/5, bit offset (b&7)*8. Bytes at or beyond rate_bytes are never written.
- Source selection: carry_data when carry_valid, otherwise msg_i masked by keep_i.
- FSM states:
  - IDLE: msg_ready_o=0. On start_i, latch rate_i and suffix_i, clear byte_cnt and the carry registers, go to ABSORB.
  - ABSORB, carry_valid: msg_ready_o=0. Absorb the carry at byte_cnt=0, clear carry_valid, set byte_cnt=n. If carry_last, go to PAD.
  - ABSORB, no carry: msg_ready_o=1. On handshake, state_we_o=1 and absorb the beat. Let space = rate_bytes - byte_cnt.
    - n < space: byte_cnt += n. If last_i, go to PAD; otherwise stay.
    - n >= space: write space bytes, byte_cnt=0, go to PERM_WAIT.
    - n > space: carry_data = masked msg >> space*8, carry_keep = keep >> space, carry_valid=1, carry_last=last_i.
    - n == space and last_i: pad_pending=1, because padding goes into a fresh block.
  - PAD: state_we_o=1. XOR suffix at byte byte_cnt and 0x80 at byte rate_bytes-1. These are the same byte when byte_cnt = rate_bytes-1, giving suffix^0x80. Set final_flag and go to PERM_WAIT.
  - PERM_WAIT: perm_req_o=1, msg_ready_o=0. On perm_done_i, drop perm_req_o the next cycle. Next state: DONE if final_flag; PAD (byte_cnt=0, clear pad_pending) if pad_pending; otherwise ABSORB.
  - DONE: absorb_done_o=1. On start_i, behave as in IDLE.
- perm_done_i outside PERM_WAIT is ignored. Beats presented outside ABSORB are not accepted.

## Timing
- Reset values: all outputs 0, FSM=IDLE, byte_cnt=0, carry and flags cleared.
- Reset asserted mid-operation: the block returns to IDLE on the next edge and the partial message is discarded.
- Beat absorb: state_we_o is asserted in the handshake cycle, so latency to the state register is 0 cycles.
- Throughput: 1 beat per cycle while in ABSORB. Each carry costs one extra cycle after the permutation.
- perm_req_o rises the cycle after the block fills or PAD executes.
- absorb_done_o rises the cycle after perm_done_i for the final block.
- start_i while busy (ABSORB, PAD, PERM_WAIT) is ignored.

## Test plan
- Empty message, SHA3-256 (rate 1088, 136 B): one beat with keep=0, last=1 -> PAD: byte0 ^= 0x06, byte135 ^= 0x80 -> one perm -> absorb_done_o=1.
- Unaligned: three 5-byte beats (keep=0x1F), last on the third -> bytes at offsets 0, 5, 10; suffix at byte15; byte_cnt never 64-bit aligned.
- Carry: SHA3-256, five full 32-byte beats -> beat 5 fills bytes 128..135, perm_req_o=1. After perm_done_i, carry bytes 8..31 of beat 5 land at state bytes 0..23 with msg_ready_o=0 that cycle; then byte_cnt=24.
- Exact fill with last: SHA3-256, 4x32 B + 8 B last -> perm, then a PAD block with byte0=0x06, byte135=0x80 -> second perm -> done.
- Same-byte pad: SHAKE128 (168 B) with 167 bytes -> byte167 ^= 0x1F^0x80 = 0x9F.
- Stall and reset: perm_done_i delayed 30 cycles -> msg_ready_o=0 and perm_req_o=1 throughout. rst low mid-ABSORB -> IDLE next edge, all outputs 0.
